fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter and next-address unit sitting directly upstream of the instruction memory. It drives the 12-bit fetch address and consumes the 19-bit instruction returned combinationally for that address, together with the ALU zero/carry flags. It decides the next PC: sequential, conditional branch, absolute jump, subroutine call, or return. Call and return use an internal return-address stack.

Parameters:
ADDR_W, 12, fetch address width; PC wraps modulo 2^ADDR_W
INSTR_W, 19, instruction width
STACK_DEPTH, 8, return-stack entries (power of two)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
stall  in  1  1 = hold PC and stack this cycle
instruction  in  19  instruction at current pc (combinational from memory)
zero_flag  in  1  ALU zero flag, valid in the cycle the branch is presented
carry_flag  in  1  ALU carry flag, same timing
pc  out  12  registered fetch address to instruction memory
stack_depth  out  4  current number of occupied stack entries (0..STACK_DEPTH)
stack_error  out  1  sticky: push-when-full or pop-when-empty has occurred

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, stack_depth=0, stack_error=0, stack contents don't-care. Deassertion is synchronous to clk by the surrounding design.
- One instruction per cycle. pc updates on the rising edge from the instruction presented during that cycle. No added fetch latency.
- seq = pc+1 mod 4096. The address wraps: 4095 -> 0.
- Decode priority, evaluated only when stall=0:
  - Branch: instruction[18:16]=3'b101. cond=instruction[15:14]: 00 taken if zero_flag=1; 01 if zero_flag=0; 10 if carry_flag=1; 11 if carry_flag=0. Taken: pc <= seq + sext(instruction[7:0]) mod 4096. Not taken: pc <= seq.
  - Flow: instruction[18:14]=5'b11101, fn=instruction[13:12], target=instruction[11:0]:
    - fn=11 JMP: pc <= target.
    - fn=00 CALL: push seq, pc <= target.
    - fn=01 RET: pop, pc <= popped value.
    - fn=10 reserved: pc <= seq, no stack effect.
  - Anything else: pc <= seq.
- Stack: LIFO with stack_depth as the pointer.
  - Push writes entry[depth] and increments depth.
  - Pop reads entry[depth-1] and decrements depth.
- Boundaries:
  - CALL with depth=STACK_DEPTH: the push is dropped, depth unchanged, stack_error<=1, and the jump to target still happens.
  - RET with depth=0: pc <= seq, depth stays 0, stack_error<=1.
  - stack_error clears only on reset.
- stall=1: pc, stack, depth and stack_error all hold. stall overrides every decode case, including CALL/RET. The held instruction is re-evaluated when stall drops, using the flags present in that cycle.
- Reset asserted mid-CALL or mid-stall: the asynchronous reset wins immediately. No partial push survives, since depth returns to 0.
- Offset arithmetic: the 8-bit two's-complement offset is sign-extended to 12 bits and added modulo 4096. Example: pc=2 with offset 0xFA gives 3-6 = 4093.

Test Plan:
- Reset then free-run with NOP (19'b0) instructions -> pc sequence 0,1,2,...; at pc=4095 the next pc is 0. Assert rst=0 mid-run -> pc=0 immediately, without waiting for a clock edge.
- pc=4, instruction {3'b101,2'b00,6'b111000,8'h06}, zero_flag=1 -> pc=11. Same with zero_flag=0 -> pc=5.
- pc=7, BranchNC with offset 8'h01, carry_flag=0 -> pc=9. pc=20, offset 8'hF0, cond=11, carry_flag=0 -> pc=5.
- pc=10, JMP target 12'h003 -> pc=3, depth unchanged. CALL at pc=30 to 0x100 -> pc=0x100, depth=1. RET -> pc=31, depth=0.
- Nine successive CALLs -> depth saturates at 8 and stack_error=1 after the 9th, while pc still follows targets. Eight RETs then return the correct LIFO addresses. A RET at depth 0 -> pc=seq and stack_error stays 1.
- Hold stall=1 for 3 cycles while a CALL is presented -> pc and depth frozen. Release stall -> exactly one push and the jump happens.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program counter and next-address unit: sequential, conditional branch, jump,
// call and return with an internal return-address stack.
module fetch_sequencer #(
  parameter int unsigned            ADDR_W      = 12,
  parameter int unsigned            INSTR_W     = 19,
  parameter int unsigned            STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0]      RESET_PC    = '0,
  localparam int unsigned           PtrW        = $clog2(STACK_DEPTH),
  localparam int unsigned           DepthW      = PtrW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               zero_flag,
  input  logic               carry_flag,
  output logic [ADDR_W-1:0]  pc,
  output logic [DepthW-1:0]  stack_depth,
  output logic               stack_error
);

  localparam logic [DepthW-1:0] DepthFull = DepthW'(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] seq, offset, target;
  logic [PtrW-1:0]   push_idx, pop_idx;
  logic              is_branch, is_flow, taken, push_en;
  logic [1:0]        fn;

  assign seq       = pc_q + 1'b1;
  assign offset    = {{(ADDR_W-8){instruction[7]}}, instruction[7:0]};
  assign target    = instruction[11:0];
  assign fn        = instruction[13:12];
  assign is_branch = (instruction[18:16] == 3'b101);
  assign is_flow   = (instruction[18:14] == 5'b11101);
  assign push_idx  = depth_q[PtrW-1:0];
  assign pop_idx   = PtrW'(depth_q - 1'b1);

  always_comb begin
    taken = 1'b0;
    unique case (instruction[15:14])
      2'b00: taken = zero_flag;
      2'b01: taken = ~zero_flag;
      2'b10: taken = carry_flag;
      2'b11: taken = ~carry_flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (!stall) begin
      pc_d = seq;
      if (is_branch) begin
        if (taken) pc_d = seq + offset;
      end else if (is_flow) begin
        unique case (fn)
          2'b11: pc_d = target;
          2'b00: begin
            // A call on a full stack still jumps; only the push is lost.
            pc_d = target;
            if (depth_q == DepthFull) begin
              err_d = 1'b1;
            end else begin
              push_en = 1'b1;
              depth_d = depth_q + 1'b1;
            end
          end
          2'b01: begin
            if (depth_q == '0) begin
              err_d = 1'b1;
            end else begin
              pc_d    = stack_q[pop_idx];
              depth_d = depth_q - 1'b1;
            end
          end
          default: pc_d = seq;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset: depth alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= seq;
  end

  assign pc          = pc_q;
  assign stack_depth = depth_q;
  assign stack_error = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomized checks of fetch_sequencer against an arithmetic
// reference model with a queue-based return stack.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [18:0] instruction = '0;
  logic        zero_flag = 1'b0;
  logic        carry_flag = 1'b0;
  logic [11:0] pc;
  logic [3:0]  stack_depth;
  logic        stack_error;

  int n_tests = 0;
  int n_fail  = 0;

  int m_pc;
  int m_stack[$];
  bit m_err;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .instruction (instruction),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .pc          (pc),
    .stack_depth (stack_depth),
    .stack_error (stack_error)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk_jmp(input logic [11:0] t);
    return {5'b11101, 2'b11, t};
  endfunction
  function automatic logic [18:0] mk_call(input logic [11:0] t);
    return {5'b11101, 2'b00, t};
  endfunction
  function automatic logic [18:0] mk_ret();
    return {5'b11101, 2'b01, 12'h000};
  endfunction
  function automatic logic [18:0] mk_br(input logic [1:0] cond, input logic [7:0] off);
    return {3'b101, cond, 6'b000000, off};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, {20'd0, pc}, m_pc);
    check({tag, ".depth"}, {28'd0, stack_depth}, m_stack.size());
    check({tag, ".err"}, {31'd0, stack_error}, {31'd0, m_err});
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  // Next-PC rules computed directly from the instruction fields.
  task automatic model_step(input logic [18:0] ins, input logic z, input logic c,
                            input logic s);
    int  seq;
    int  off;
    byte b;
    bit  tk;
    if (s) return;
    seq = (m_pc + 1) % 4096;
    if (ins[18:16] == 3'b101) begin
      case (ins[15:14])
        2'b00: tk = z;
        2'b01: tk = !z;
        2'b10: tk = c;
        default: tk = !c;
      endcase
      b   = ins[7:0];
      off = b;
      m_pc = tk ? (seq + off + 4096) % 4096 : seq;
    end else if (ins[18:14] == 5'b11101) begin
      case (ins[13:12])
        2'b11: m_pc = ins[11:0];
        2'b00: begin
          if (m_stack.size() < 8) m_stack.push_back(seq);
          else m_err = 1'b1;
          m_pc = ins[11:0];
        end
        2'b01: begin
          if (m_stack.size() > 0) m_pc = m_stack.pop_back();
          else begin
            m_pc  = seq;
            m_err = 1'b1;
          end
        end
        default: m_pc = seq;
      endcase
    end else begin
      m_pc = seq;
    end
  endtask

  task automatic step(input string tag, input logic [18:0] ins, input logic z,
                      input logic c, input logic s);
    instruction = ins;
    zero_flag   = z;
    carry_flag  = c;
    stall       = s;
    model_step(ins, z, c, s);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();

    for (int i = 0; i < 3; i++) step("nop", '0, 1'b0, 1'b0, 1'b0);
    step("jmp_fff", mk_jmp(12'hFFF), 1'b0, 1'b0, 1'b0);
    step("wrap", '0, 1'b0, 1'b0, 1'b0);
    check("wrap_zero", {20'd0, pc}, 32'd0);

    // Asynchronous reset mid-run, observed before any clock edge.
    step("nop", '0, 1'b0, 1'b0, 1'b0);
    step("nop", '0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;

    step("jmp4", mk_jmp(12'd4), 1'b0, 1'b0, 1'b0);
    step("bz_taken", {3'b101, 2'b00, 6'b111000, 8'h06}, 1'b1, 1'b0, 1'b0);
    check("bz_taken_11", {20'd0, pc}, 32'd11);
    step("jmp4", mk_jmp(12'd4), 1'b0, 1'b0, 1'b0);
    step("bz_not", {3'b101, 2'b00, 6'b111000, 8'h06}, 1'b0, 1'b0, 1'b0);
    check("bz_not_5", {20'd0, pc}, 32'd5);
    step("jmp7", mk_jmp(12'd7), 1'b0, 1'b0, 1'b0);
    step("bnc", mk_br(2'b11, 8'h01), 1'b0, 1'b0, 1'b0);
    check("bnc_9", {20'd0, pc}, 32'd9);
    step("jmp20", mk_jmp(12'd20), 1'b0, 1'b0, 1'b0);
    step("bnc_back", mk_br(2'b11, 8'hF0), 1'b0, 1'b0, 1'b0);
    check("bnc_back_5", {20'd0, pc}, 32'd5);
    step("jmp2", mk_jmp(12'd2), 1'b0, 1'b0, 1'b0);
    step("bnz_neg", mk_br(2'b01, 8'hFA), 1'b0, 1'b0, 1'b0);
    check("bnz_wrap_4093", {20'd0, pc}, 32'd4093);
    step("bc_not", mk_br(2'b10, 8'h10), 1'b0, 1'b0, 1'b0);
    step("rsvd", {5'b11101, 2'b10, 12'h123}, 1'b0, 1'b0, 1'b0);

    step("jmp10", mk_jmp(12'd10), 1'b0, 1'b0, 1'b0);
    step("jmp3", mk_jmp(12'h003), 1'b0, 1'b0, 1'b0);
    step("jmp30", mk_jmp(12'd30), 1'b0, 1'b0, 1'b0);
    step("call100", mk_call(12'h100), 1'b0, 1'b0, 1'b0);
    check("call_pc", {20'd0, pc}, 32'h100);
    step("ret", mk_ret(), 1'b0, 1'b0, 1'b0);
    check("ret_pc_31", {20'd0, pc}, 32'd31);

    for (int i = 0; i < 9; i++) step("call9", mk_call(12'(12'h200 + i * 16)), 1'b0, 1'b0, 1'b0);
    check("sat_err", {31'd0, stack_error}, 32'd1);
    check("sat_depth", {28'd0, stack_depth}, 32'd8);
    for (int i = 0; i < 8; i++) step("ret8", mk_ret(), 1'b0, 1'b0, 1'b0);
    step("ret_empty", mk_ret(), 1'b0, 1'b0, 1'b0);

    do_reset();
    step("jmp50", mk_jmp(12'd50), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("stall_call", mk_call(12'h080), 1'b0, 1'b0, 1'b1);
    step("unstall_call", mk_call(12'h080), 1'b0, 1'b0, 1'b0);
    check("unstall_depth1", {28'd0, stack_depth}, 32'd1);
    step("stall_ret", mk_ret(), 1'b0, 1'b0, 1'b1);
    step("unstall_ret", mk_ret(), 1'b0, 1'b0, 1'b0);
    check("unstall_ret_51", {20'd0, pc}, 32'd51);

    for (int n = 0; n < 400; n++) begin
      logic [18:0] ins;
      int          k;
      if (n == 200) do_reset();
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    ins = 19'($urandom);
        2, 3:    ins = mk_br(2'($urandom), 8'($urandom));
        4:       ins = mk_jmp(12'($urandom));
        5, 6:    ins = mk_call(12'($urandom));
        7, 8:    ins = mk_ret();
        default: ins = {5'b11101, 2'b10, 12'($urandom)};
      endcase
      step("rand", ins, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
